// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers with byte-merged
// writes, a four-state count FSM and a maskable, level-style interrupt request.
module timer_counter #(
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:2]  addr,
    input  logic        we,
    input  logic [3:0]  byteEn,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } state_t;

    state_t             state_reg;
    logic [CTRL_W-1:0]  ctrl_reg;
    logic [CNT_W-1:0]   preset_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               irq_flag_reg;

    logic [31:0]        byte_mask;
    logic [CTRL_W-1:0]  ctrl_merged;
    logic [CNT_W-1:0]   preset_merged;
    logic               wr_ctrl;
    logic               wr_preset;
    logic               fsm_set_flag;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
        assign byte_mask[8*gi +: 8] = {8{byteEn[gi]}};
    end

    assign ctrl_merged   = (ctrl_reg & ~byte_mask[CTRL_W-1:0]) |
                           (din[CTRL_W-1:0] & byte_mask[CTRL_W-1:0]);
    assign preset_merged = (preset_reg & ~byte_mask[CNT_W-1:0]) |
                           (din[CNT_W-1:0] & byte_mask[CNT_W-1:0]);

    // An all-zero byteEn is a no-op, so it must not clear the pending flag either.
    assign wr_ctrl      = we && (addr == 2'b00) && (|byteEn);
    assign wr_preset    = we && (addr == 2'b01) && (|byteEn);
    assign fsm_set_flag = (state_reg == CNT) && ctrl_reg[0] && (count_reg <= CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ctrl_reg     <= '0;
            preset_reg   <= '0;
            count_reg    <= '0;
            irq_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ctrl_reg[0]) state_reg <= LOAD;
                end
                LOAD: begin
                    count_reg <= preset_reg;
                    state_reg <= CNT;
                end
                CNT: begin
                    if (!ctrl_reg[0]) begin
                        state_reg <= IDLE;
                    end else if (count_reg > CNT_W'(1)) begin
                        count_reg <= count_reg - CNT_W'(1);
                    end else begin
                        count_reg    <= '0;
                        irq_flag_reg <= 1'b1;
                        state_reg    <= INT;
                    end
                end
                INT: begin
                    // Auto-reload returns straight to LOAD, giving a PRESET+2 period.
                    if (ctrl_reg[2:1] == 2'b01) begin
                        irq_flag_reg <= 1'b0;
                        state_reg    <= ctrl_reg[0] ? LOAD : IDLE;
                    end else begin
                        ctrl_reg[0]  <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Bus updates come last so a CTRL write overrides the FSM's EN clear.
            if (wr_ctrl)   ctrl_reg   <= ctrl_merged;
            if (wr_preset) preset_reg <= preset_merged;
            if ((wr_ctrl || wr_preset) && !fsm_set_flag) irq_flag_reg <= 1'b0;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            2'b00:   dout = 32'(ctrl_reg);
            2'b01:   dout = 32'(preset_reg);
            2'b10:   dout = 32'(count_reg);
            default: dout = '0;
        endcase
    end

    assign irq = irq_flag_reg & ctrl_reg[3];

endmodule
